// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan driver.
// Holds blanking codes and default scan geometry used by seg_scan and its bench.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK       = 8'hFF;
  localparam logic [7:0] AN_OFF          = 8'hFF;
  localparam int         DIGITS_DEF      = 8;
  localparam int         REFRESH_DIV_DEF = 100000;

endpackage

// File: rtl/seg_scan_bcd7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Output bits 6:0 map to segments g..a; a low bit lights the segment.
module bcd7seg (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit common-anode display driver showing the last four received bytes.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS      = DIGITS_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  input  logic       clear,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic [2:0] digit_idx
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [31:0]      hist_q, hist_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [2:0]       digit_idx_q, digit_idx_d;
  logic             wrap;
  logic [3:0]       nib;
  logic [6:0]       dec;
  logic             blank;

  // A strobe coinciding with clear lands in an otherwise empty history.
  always_comb begin
    hist_d = hist_q;
    if (clear)
      hist_d = 32'h0;
    if (in_valid)
      hist_d = {(clear ? 24'h0 : hist_q[23:0]), in_byte};
  end

  always_comb begin
    wrap      = (div_cnt_q == CNT_W'(REFRESH_DIV - 1));
    div_cnt_d = wrap ? '0 : div_cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (wrap)
      idx_d = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
  end

  assign nib = hist_q[{idx_q, 2'b00} +: 4];

  bcd7seg u_dec (
    .nib_i (nib),
    .seg_o (dec)
  );

`ifdef SEG_SCAN_LZB_EN
  logic [2:0] top_nz;

  // Highest non-zero nibble wins; an all-zero history still shows digit 0.
  always_comb begin
    top_nz = 3'd0;
    for (int i = 1; i < 8; i++)
      if (hist_q[4*i +: 4] != 4'h0)
        top_nz = 3'(i);
    blank = (idx_q > top_nz);
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_d        = blank ? AN_OFF : ~(8'b1 << idx_q);
    seg_d       = blank ? SEG_BLANK : {1'b1, dec};
    digit_idx_d = idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q      <= 32'h0;
      div_cnt_q   <= '0;
      idx_q       <= 3'd0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      digit_idx_q <= 3'd0;
    end else begin
      hist_q      <= hist_d;
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign digit_idx = digit_idx_q;

endmodule
